// File: rtl/keypad_pkg.sv
`default_nettype none
// ============================================================================
// keypad_pkg : shared strobe constants, key encoding and debounce states
// Revision   : 1.0
// ============================================================================
package keypad_pkg;

  localparam int KEY_W = 4;

  localparam logic [3:0] COL0 = 4'b1110;
  localparam logic [3:0] COL1 = 4'b1101;
  localparam logic [3:0] COL2 = 4'b1011;
  localparam logic [3:0] COL3 = 4'b0111;

  typedef enum logic [1:0] {
    RELEASED   = 2'd0,
    PRESS_PEND = 2'd1,
    PRESSED    = 2'd2,
    REL_PEND   = 2'd3
  } db_state_e;

  // "No key" is carried by a separate valid flag; its code is kept at zero
  // so that two NONE candidates always compare equal.
  typedef struct packed {
    logic             valid;
    logic [KEY_W-1:0] code;
  } key_cand_t;

  localparam key_cand_t KEY_NONE = '{valid: 1'b0, code: '0};

  function automatic logic [3:0] col_strobe(input logic [1:0] idx);
    logic [3:0] s;
    case (idx)
      2'd0:    s = COL0;
      2'd1:    s = COL1;
      2'd2:    s = COL2;
      default: s = COL3;
    endcase
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/scan_strobe_gen.sv
`default_nettype none
// ============================================================================
// scan_strobe_gen : column-slot divider driving active-low column strobes
// Revision        : 1.0
// ============================================================================
module scan_strobe_gen
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 65536
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] col_o,
  output logic [1:0] col_idx_o,
  output logic       sample_tick_o
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] slot_q, slot_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic             tick;

  assign tick = (slot_q == SLOT_LAST);

  always_comb begin
    slot_d    = slot_q + 1'b1;
    col_idx_d = col_idx_q;
    if (tick) begin
      slot_d    = '0;
      col_idx_d = col_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q    <= '0;
      col_idx_q <= 2'd0;
    end else begin
      slot_q    <= slot_d;
      col_idx_q <= col_idx_d;
    end
  end

  assign col_o         = col_strobe(col_idx_q);
  assign col_idx_o     = col_idx_q;
  assign sample_tick_o = tick;

endmodule
`default_nettype wire

// File: rtl/keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// keypad_matrix_scanner : 4x4 keypad scan, whole-scan debounce, key pulse
// Revision              : 1.0
// ============================================================================
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 65536,
  parameter int DB_SCANS = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [3:0]       col,
  input  logic [3:0]       row,
  output logic [KEY_W-1:0] key_code,
  output logic             key_down,
  output logic             key_valid
);

  localparam int DB_W = $clog2(DB_SCANS + 1);
  localparam logic [DB_W-1:0] DB_LIM = DB_W'(DB_SCANS);
  localparam logic [DB_W-1:0] DB_ONE = DB_W'(1);

  logic [1:0] col_idx;
  logic       sample_tick;

  scan_strobe_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_strobe (
    .clk           (clk),
    .rst           (rst),
    .col_o         (col),
    .col_idx_o     (col_idx),
    .sample_tick_o (sample_tick)
  );

  logic [3:0]  sync0_q, sync1_q;
  logic [15:0] snap_q;
  logic        scan_done_q;
  key_cand_t   cand_q, cand_d;
  logic        cand_stb_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync0_q     <= '0;
      sync1_q     <= '0;
      snap_q      <= '0;
      scan_done_q <= 1'b0;
      cand_q      <= KEY_NONE;
      cand_stb_q  <= 1'b0;
    end else begin
      sync0_q     <= row;
      sync1_q     <= sync0_q;
      if (sample_tick) begin
        snap_q[{col_idx, 2'b00} +: 4] <= ~sync1_q;
      end
      scan_done_q <= sample_tick && (col_idx == 2'd3);
      cand_q      <= cand_d;
      cand_stb_q  <= scan_done_q;
    end
  end

  // Anything other than exactly one closed contact (idle or ghosting) is NONE.
  logic [4:0]       hit_cnt;
  logic [KEY_W-1:0] hit_idx;

  always_comb begin
    hit_cnt = '0;
    hit_idx = '0;
    for (int b = 0; b < 16; b++) begin
      if (snap_q[b]) begin
        hit_cnt = hit_cnt + 5'd1;
        hit_idx = KEY_W'(b);
      end
    end
    cand_d = KEY_NONE;
    if (hit_cnt == 5'd1) begin
      cand_d = '{valid: 1'b1, code: hit_idx};
    end
  end

  db_state_e        state_q, state_d;
  logic [DB_W-1:0]  cnt_q, cnt_d, cnt_inc;
  key_cand_t        pend_q, pend_d;
  logic [KEY_W-1:0] key_code_q, key_code_d;
  logic             key_down_q, key_down_d;
  logic             key_valid_q, key_valid_d;
  logic             settle;
  logic             is_held;

  assign cnt_inc = (cnt_q >= DB_LIM) ? cnt_q : cnt_q + DB_ONE;
  assign is_held = cand_q.valid && (cand_q.code == key_code_q);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    key_code_d  = key_code_q;
    key_down_d  = key_down_q;
    key_valid_d = 1'b0;
    settle      = 1'b0;
    if (cand_stb_q) begin
      case (state_q)
        RELEASED: begin
          if (cand_q.valid) begin
            state_d = PRESS_PEND;
            pend_d  = cand_q;
            cnt_d   = DB_ONE;
            settle  = 1'b1;
          end
        end
        PRESS_PEND: begin
          if (!cand_q.valid) begin
            state_d = RELEASED;
            cnt_d   = '0;
          end else if (cand_q == pend_q) begin
            cnt_d  = cnt_inc;
            settle = 1'b1;
          end else begin
            pend_d = cand_q;
            cnt_d  = DB_ONE;
            settle = 1'b1;
          end
        end
        PRESSED: begin
          if (!is_held) begin
            state_d = REL_PEND;
            pend_d  = cand_q;
            cnt_d   = DB_ONE;
            settle  = 1'b1;
          end
        end
        default: begin
          if (is_held) begin
            state_d = PRESSED;
            cnt_d   = '0;
          end else if (cand_q == pend_q) begin
            cnt_d  = cnt_inc;
            settle = 1'b1;
          end else begin
            pend_d = cand_q;
            cnt_d  = DB_ONE;
            settle = 1'b1;
          end
        end
      endcase
      // A run that just reached the limit resolves to the candidate it counted.
      if (settle && (cnt_d >= DB_LIM)) begin
        cnt_d = '0;
        if (cand_q.valid) begin
          state_d     = PRESSED;
          key_code_d  = cand_q.code;
          key_down_d  = 1'b1;
          key_valid_d = 1'b1;
        end else begin
          state_d    = RELEASED;
          key_down_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RELEASED;
      cnt_q       <= '0;
      pend_q      <= KEY_NONE;
      key_code_q  <= '0;
      key_down_q  <= 1'b0;
      key_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      key_code_q  <= key_code_d;
      key_down_q  <= key_down_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign key_code  = key_code_q;
  assign key_down  = key_down_q;
  assign key_valid = key_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_keypad_matrix_scanner.sv
`default_nettype none
// ============================================================================
// tb_keypad_matrix_scanner : keypad matrix model, scan-level reference, scoreboard
// Revision                 : 1.0
// ============================================================================
module tb_keypad_matrix_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DB_SCANS = 3;
  localparam int SCAN_LEN = 4 * SCAN_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  col;
  logic [3:0]  row;
  logic [3:0]  key_code;
  logic        key_down;
  logic        key_valid;
  logic [15:0] mask = '0;
  logic        finish_req = 1'b0;

  keypad_matrix_scanner #(
    .SCAN_DIV (SCAN_DIV),
    .DB_SCANS (DB_SCANS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .col       (col),
    .row       (row),
    .key_code  (key_code),
    .key_down  (key_down),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key shorts its row low while its column is strobed.
  always_comb begin
    row = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (col == ~(4'b0001 << i)) begin
        for (int j = 0; j < 4; j++) begin
          if (mask[4*i+j]) row[j] = 1'b0;
        end
      end
    end
  end

  typedef struct {
    int         k;
    logic [3:0] code;
  } pulse_t;

  typedef struct {
    int         k;
    logic       down;
    logic [3:0] code;
  } state_t;

  pulse_t pq[$];
  state_t sq[$];

  // ---------------- reference model (one call per full scan) ----------------
  int         n_scan  = 0;
  int         deb     = -1;
  int         run_key = -1;
  int         run_len = 0;
  logic       m_down  = 1'b0;
  logic [3:0] m_code  = 4'h0;

  function automatic logic [15:0] key(input int i, input int j);
    logic [15:0] m;
    m = '0;
    m[4*i+j] = 1'b1;
    return m;
  endfunction

  task automatic model_scan(input logic [15:0] m);
    int cand;
    int ke;
    cand = -1;
    ke   = SCAN_LEN * n_scan + SCAN_LEN + 2;
    if ($countones(m) == 1) begin
      for (int b = 0; b < 16; b++) if (m[b]) cand = b;
    end
    if (cand == deb) begin
      run_len = 0;
    end else if (run_len > 0 && cand == run_key) begin
      run_len++;
    end else begin
      run_key = cand;
      run_len = 1;
    end
    if (run_len >= DB_SCANS) begin
      deb     = cand;
      run_len = 0;
      if (cand >= 0) begin
        m_code = 4'(cand);
        pq.push_back('{k: ke, code: m_code});
      end
    end
    m_down = (deb >= 0);
    sq.push_back('{k: ke, down: m_down, code: m_code});
    n_scan++;
  endtask

  task automatic run_scans(input logic [15:0] m, input int n);
    for (int s = 0; s < n; s++) begin
      mask = m;
      model_scan(m);
      repeat (SCAN_LEN) @(negedge clk);
    end
  endtask

  task automatic do_reset(input int cyc);
    rst     = 1'b1;
    deb     = -1;
    run_key = -1;
    run_len = 0;
    m_down  = 1'b0;
    m_code  = 4'h0;
    n_scan  = 0;
    repeat (cyc) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  int         k = 0;
  int         checks = 0;
  int         passed = 0;
  logic       exp_down = 1'b0;
  logic [3:0] exp_code = 4'h0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s at k=%0d: actual=%0h required=%0h", nm, k, act, exp);
  endtask

  always @(posedge clk) begin
    logic       exp_v;
    logic [3:0] exp_col;
    #1;
    if (rst) begin
      k        = 0;
      exp_down = 1'b0;
      exp_code = 4'h0;
      pq.delete();
      sq.delete();
    end else begin
      k = k + 1;
    end
    while (sq.size() > 0 && sq[0].k <= k) begin
      exp_down = sq[0].down;
      exp_code = sq[0].code;
      void'(sq.pop_front());
    end
    exp_col = rst ? 4'b1110 : ~(4'b0001 << ((k / SCAN_DIV) % 4));
    chk("col", col, exp_col);
    exp_v = (pq.size() > 0 && pq[0].k == k);
    chk("key_valid", key_valid, exp_v);
    if (exp_v) begin
      chk("pulse_code", key_code, pq[0].code);
      void'(pq.pop_front());
    end
    chk("key_down", key_down, exp_down);
    chk("key_code", key_code, exp_code);
    if (finish_req) begin
      chk("pulses_outstanding", pq.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    do_reset(3);
    run_scans('0, 4);                                   // idle strobing
    run_scans(key(2, 1), 3);                            // press key 9
    run_scans('0, 4);                                   // release
    run_scans(key(0, 0), 2);                            // bounce
    run_scans('0, 1);
    run_scans(key(0, 0), 3);
    run_scans('0, 4);
    run_scans(key(1, 3) | key(3, 3), 5);                // ghosting pair
    run_scans('0, 1);
    run_scans(key(1, 1), 3);                            // roll 5 -> 14
    run_scans(key(3, 2), 3);
    run_scans('0, 4);
    run_scans(key(1, 3), 2);                            // reset in PRESS_PEND
    repeat (7) @(negedge clk);
    do_reset(2);
    run_scans(key(1, 3), 3);
    run_scans('0, 4);
    for (int r = 0; r < 60; r++) begin
      logic [15:0] m;
      int          sel;
      sel = int'($urandom_range(0, 5));
      if (sel < 2)       m = '0;
      else if (sel < 5)  m = key(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      else               m = key(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)))
                           | key(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      run_scans(m, int'($urandom_range(1, 4)));
    end
    run_scans('0, 4);
    repeat (8) @(negedge clk);
    finish_req = 1'b1;
    repeat (4) @(negedge clk);
    $display("FAIL summary_not_reached: actual=0 required=1");
    $fatal(1);
  end

endmodule
`default_nettype wire
